// File: rtl/exec_pkg.sv
// Shared widths, ALU opcodes and the operand bundle carried by each execute lane.
package exec_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 5;
  localparam int OP_W   = 4;
  localparam int OPND_W = DATA_W + TAG_W;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_ROL  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_ROR  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_SHL  = 4'b1100;

  typedef logic [OPND_W-1:0] opnd_t;

  typedef struct packed {
    opnd_t            r0;
    opnd_t            r1;
    logic [TAG_W-1:0] imm;
    logic             imm_sel;
    logic [OP_W-1:0]  op;
  } issue_bundle_t;
endpackage

// File: rtl/rr_pick.sv
// Circular first-eligible picker: scans from ptr upward, wrapping at N-1, skipping masked entries.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          found
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % N);
  endfunction

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && eligible[wrap_idx(ptr, k)] && !mask[wrap_idx(ptr, k)]) begin
        found                  = 1'b1;
        grant[wrap_idx(ptr, k)] = 1'b1;
        index                  = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/exec_issue_arbiter.sv
// Round-robin issue of reservation-station requests onto ALU lanes A0/A1 and the MUL lane,
// with per-lane registered operand bundles that hold while writeback stalls the lane.
module exec_issue_arbiter
  import exec_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_is_mul,
  input  logic [NUM_REQ*OPND_W-1:0] req_r0,
  input  logic [NUM_REQ*OPND_W-1:0] req_r1,
  input  logic [NUM_REQ*TAG_W-1:0]  req_imm,
  input  logic [NUM_REQ-1:0]        req_imm_sel,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      a0_stall,
  input  logic                      a1_stall,
  input  logic                      m_stall,
  output logic                      a0_valid,
  output logic [OPND_W-1:0]         a0_r0,
  output logic [OPND_W-1:0]         a0_r1,
  output logic [TAG_W-1:0]          a0_imm,
  output logic                      a0_imm_sel,
  output logic [OP_W-1:0]           a0_op,
  output logic                      a1_valid,
  output logic [OPND_W-1:0]         a1_r0,
  output logic [OPND_W-1:0]         a1_r1,
  output logic [TAG_W-1:0]          a1_imm,
  output logic                      a1_imm_sel,
  output logic [OP_W-1:0]           a1_op,
  output logic                      m_valid,
  output logic [OPND_W-1:0]         m_r0,
  output logic [OPND_W-1:0]         m_r1,
  output logic [TAG_W-1:0]          m_imm,
  output logic                      m_imm_sel
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  issue_bundle_t        bundle [NUM_REQ];
  logic [PW-1:0]        alu_ptr, mul_ptr;
  logic [NUM_REQ-1:0]   alu_elig, mul_elig;
  logic [NUM_REQ-1:0]   g_first, g_second, g_mul;
  logic [PW-1:0]        idx_first, idx_second, idx_mul, a1_idx;
  logic                 found_first, found_second, found_mul;
  logic                 a0_free, a1_free, m_free;
  logic                 take_first, take_second, take_mul, a1_take;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bundle[i].r0      = req_r0[i*OPND_W +: OPND_W];
      bundle[i].r1      = req_r1[i*OPND_W +: OPND_W];
      bundle[i].imm     = req_imm[i*TAG_W +: TAG_W];
      bundle[i].imm_sel = req_imm_sel[i];
      bundle[i].op      = req_op[i*OP_W +: OP_W];
    end
  end

  assign alu_elig = req_valid & ~req_is_mul;
  assign mul_elig = req_valid & req_is_mul;

  // Second ALU picker sees the same pointer with the first winner masked out,
  // so it yields the next eligible requester in circular order.
  rr_pick #(.N(NUM_REQ), .IW(PW)) u_alu_first (
    .eligible(alu_elig), .ptr(alu_ptr), .mask({NUM_REQ{1'b0}}),
    .grant(g_first), .index(idx_first), .found(found_first)
  );

  rr_pick #(.N(NUM_REQ), .IW(PW)) u_alu_second (
    .eligible(alu_elig), .ptr(alu_ptr), .mask(g_first),
    .grant(g_second), .index(idx_second), .found(found_second)
  );

  rr_pick #(.N(NUM_REQ), .IW(PW)) u_mul (
    .eligible(mul_elig), .ptr(mul_ptr), .mask({NUM_REQ{1'b0}}),
    .grant(g_mul), .index(idx_mul), .found(found_mul)
  );

  assign a0_free = !a0_valid || !a0_stall;
  assign a1_free = !a1_valid || !a1_stall;
  assign m_free  = !m_valid  || !m_stall;

  assign take_first  = found_first && (a0_free || a1_free);
  assign take_second = found_second && a0_free && a1_free;
  assign take_mul    = found_mul && m_free;

  // With A0 blocked, the first winner falls through to A1.
  assign a1_take = a0_free ? found_second : found_first;
  assign a1_idx  = a0_free ? idx_second : idx_first;

  assign req_ready = !rst_n ? '0 :
                     ((take_first  ? g_first  : '0) |
                      (take_second ? g_second : '0) |
                      (take_mul    ? g_mul    : '0));

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ptr <= '0;
      mul_ptr <= '0;
    end else begin
      if (take_second)     alu_ptr <= inc_wrap(idx_second);
      else if (take_first) alu_ptr <= inc_wrap(idx_first);
      if (take_mul)        mul_ptr <= inc_wrap(idx_mul);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_valid <= 1'b0; a0_r0 <= '0; a0_r1 <= '0; a0_imm <= '0; a0_imm_sel <= 1'b0; a0_op <= '0;
    end else if (a0_free) begin
      a0_valid <= found_first;
      if (found_first) begin
        a0_r0      <= bundle[idx_first].r0;
        a0_r1      <= bundle[idx_first].r1;
        a0_imm     <= bundle[idx_first].imm;
        a0_imm_sel <= bundle[idx_first].imm_sel;
        a0_op      <= bundle[idx_first].op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_valid <= 1'b0; a1_r0 <= '0; a1_r1 <= '0; a1_imm <= '0; a1_imm_sel <= 1'b0; a1_op <= '0;
    end else if (a1_free) begin
      a1_valid <= a1_take;
      if (a1_take) begin
        a1_r0      <= bundle[a1_idx].r0;
        a1_r1      <= bundle[a1_idx].r1;
        a1_imm     <= bundle[a1_idx].imm;
        a1_imm_sel <= bundle[a1_idx].imm_sel;
        a1_op      <= bundle[a1_idx].op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_r0 <= '0; m_r1 <= '0; m_imm <= '0; m_imm_sel <= 1'b0;
    end else if (m_free) begin
      m_valid <= found_mul;
      if (found_mul) begin
        m_r0      <= bundle[idx_mul].r0;
        m_r1      <= bundle[idx_mul].r1;
        m_imm     <= bundle[idx_mul].imm;
        m_imm_sel <= bundle[idx_mul].imm_sel;
      end
    end
  end

endmodule
